// File: rtl/fifo8_pkg.sv
// Shared sizing constants and types for the 8-entry register-bank FIFO.
// DEPTH : number of storage registers
// PTR_W : pointer width (3 bits selects one of 8 registers)
// ptr_t : read/write pointer type
// count_t : occupancy type, one bit wider than a pointer so it can hold 0..8
package fifo8_pkg;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   count_t;

endpackage

// File: rtl/fifo8_regbank.sv
// Eight WIDTH-bit storage registers with a one-hot load decode and an
// 8-way read mux. Storage is deliberately not reset.
// Ports:
//   clk     : rising-edge clock
//   load    : load enable; when low no register changes
//   wr_sel  : register selected for loading
//   wr_data : word loaded into the selected register
//   rd_sel  : register driven onto rd_data
//   rd_data : contents of register rd_sel (combinational)
module fifo8_regbank
    import fifo8_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             load,
    input  ptr_t             wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  ptr_t             rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] load_onehot;

    // Steer the single load strobe to exactly one register.
    always_comb begin
        load_onehot = '0;
        if (load) begin
            load_onehot[wr_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (load_onehot[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    assign rd_data = mem[rd_sel];

endmodule

// File: rtl/fifo8_regbank_queue.sv
// 8-entry synchronous show-ahead FIFO with valid/ready handshakes on both
// sides, built around fifo8_regbank.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (control state only)
//   in_data   : word offered by the producer
//   in_valid  : producer has a word
//   in_ready  : FIFO accepts a word this cycle (not full)
//   out_data  : head-of-queue word, zero when empty
//   out_valid : out_data holds a valid word (not empty)
//   out_ready : consumer takes the word this cycle
//   count     : number of stored words, 0..8
//   full      : count == 8
//   empty     : count == 0
module fifo8_regbank_queue
    import fifo8_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output count_t           count,
    output logic             full,
    output logic             empty
);

    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rd_data;

    // Flags come from the registered count only, so a pop in the same cycle
    // never opens a slot for a push while full.
    assign full      = (count == count_t'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Pointers are 3 bits wide and wrap 7 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo8_regbank #(
        .WIDTH (WIDTH)
    ) u_regbank (
        .clk     (clk),
        .load    (push),
        .wr_sel  (wr_ptr),
        .wr_data (in_data),
        .rd_sel  (rd_ptr),
        .rd_data (rd_data)
    );

    // Stale storage contents must not leak out while empty.
    assign out_data = empty ? '0 : rd_data;

endmodule

// File: tb/tb_fifo8_regbank_queue.sv
// Self-checking bench for fifo8_regbank_queue. A reference queue and
// occupancy counter track the expected contents; every cycle the DUT flags,
// count and head word are compared against them.
module tb_fifo8_regbank_queue;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int          n_checks;
    int          n_fail;
    int          mcount;
    logic [15:0] sb_q [$];

    fifo8_regbank_queue #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check state mid-cycle against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input logic r, input logic iv, input logic [15:0] d, input logic ordy);
        logic        push_ok;
        logic        pop_ok;
        logic [15:0] exp_d;
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        exp_d = (sb_q.size() > 0) ? sb_q[0] : 16'h0000;
        check("count",     32'(count),     32'(mcount));
        check("full",      32'(full),      32'(mcount == 8));
        check("empty",     32'(empty),     32'(mcount == 0));
        check("in_ready",  32'(in_ready),  32'(mcount != 8));
        check("out_valid", 32'(out_valid), 32'(mcount != 0));
        check("out_data",  32'(out_data),  32'(exp_d));
        push_ok = iv && (mcount != 8);
        pop_ok  = ordy && (mcount != 0);
        @(posedge clk);
        if (r) begin
            sb_q.delete();
            mcount = 0;
        end else begin
            if (pop_ok) begin
                void'(sb_q.pop_front());
            end
            if (push_ok) begin
                sb_q.push_back(d);
            end
            mcount = mcount + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
        end
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mcount    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;

        // Reset for two cycles; the second cycle's checks see reset values.
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);

        // Fill to full, then one ignored push while full.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 16'(i * 16'h0011), 1'b0);
        end
        cycle(1'b0, 1'b1, 16'h0099, 1'b0);

        // Drain in order, plus extra pops while empty.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);

        // Preload three words, then concurrent traffic across the pointer wrap.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 16'(16'h00A0 + i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1);
        end
        check("wrap_count", 32'(count), 32'd3);

        // Top up to full, then push+pop at full: only the pop happens.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 16'(16'h0200 + i), 1'b0);
        end
        cycle(1'b0, 1'b1, 16'hAAAA, 1'b1);
        check("full_pop_count", 32'(count), 32'd7);
        cycle(1'b0, 1'b1, 16'hAAAA, 1'b0);
        check("refill_count", 32'(count), 32'd8);

        // Drain to five entries, then reset with push and pop both active.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        end
        cycle(1'b1, 1'b1, 16'h5555, 1'b1);
        cycle(1'b0, 1'b1, 16'hBEEF, 1'b0);
        check("beef_out", 32'(out_data), 32'h0000BEEF);
        cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, 16'h0000, 1'b0);

        // Random mixed traffic.
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        while (mcount != 0) begin
            cycle(1'b0, 1'b0, 16'h0000, 1'b1);
        end
        cycle(1'b0, 1'b0, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo8_regbank_queue.md
Name: fifo8_regbank_queue

Overview:
- 8-entry synchronous FIFO.
- Builds on the 3-bit-select load-demultiplex pattern: the write pointer steers a single load strobe to one of eight WIDTH-bit registers.
- The read pointer selects one register through an 8-way read mux.
- Sits downstream of 8-way load-decode logic as the first stateful storage stage of the memory hierarchy, buffering a producer/consumer pair with valid/ready handshakes.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_data  input  WIDTH  word offered by producer
- in_valid  input  1  producer has a word
- in_ready  output  1  FIFO accepts a word this cycle
- out_data  output  WIDTH  head-of-queue word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer takes the word this cycle
- count  output  4  number of stored words, 0..8
- full  output  1  count == 8
- empty  output  1  count == 0

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, in_ready = 1, out_valid = 0, out_data = 0.
  - Storage registers are not reset.
- Push: occurs on a clock edge when in_valid && in_ready.
  - mem[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr + 1, 3-bit, wraps 7 -> 0.
- Pop: occurs on a clock edge when out_valid && out_ready.
  - rd_ptr <= rd_ptr + 1, wraps 7 -> 0.
- Load decode: exactly one storage register loads per push, selected one-hot by wr_ptr. No register loads when there is no push.
- Output interface:
  - in_ready = !full, combinational from state only. There is no pass-through when full, even if a pop occurs the same cycle.
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when !empty, else all zeros. This is show-ahead and combinational from state.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. The empty FIFO has no same-cycle bypass.
- Count update, 4-bit, never wraps:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Simultaneous push and pop:
  - Legal whenever 0 < count < 8.
  - Both pointers advance and count holds.
  - When count == 8, no push can occur, so only the pop takes effect.
  - When count == 0, no pop can occur, so only the push takes effect.
- Ignored inputs: in_valid while full and out_ready while empty are ignored. They cause no state change and no error.
- Pointer relationship: wr_ptr == rd_ptr in both the full and empty states; count disambiguates.
- Reset mid-operation: rst dominates push and pop in the same cycle. All contents are logically discarded. The next cycle shows the reset values.
- Input stability: in_data is sampled only at the push edge. The producer may change it freely otherwise.

Decomposition:
- Package fifo8_pkg holds:
  - localparam DEPTH = 8
  - localparam PTR_W = 3
  - typedef logic [PTR_W-1:0] ptr_t
  - typedef logic [PTR_W:0] count_t
- Sub-module fifo8_regbank:
  - Contains 8 x WIDTH registers, the one-hot load decode from a 3-bit select plus a load enable, and the 8-way read mux from a 3-bit select.
  - Ports: clk, load, wr_sel, wr_data, rd_sel, rd_data.
- Top level holds:
  - pointers
  - count
  - flag logic
  - handshake qualification
  - the out_data zero-forcing

Test Plan:
- Reset then idle: assert rst 2 cycles, deassert -> count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0.
- Fill to full: push 0x0011..0x0088 on 8 consecutive cycles with out_ready=0 -> count steps 1..8; full=1 and in_ready=0 after 8th edge; 9th in_valid with 0x0099 is ignored, count stays 8.
- Drain in order: from full, hold out_ready=1 -> out_data sequence 0x0011..0x0088 one per cycle; empty=1 and out_data=0 after 8th pop; extra out_ready causes no change.
- Wrap-around with concurrent traffic: preload 3 words, then 20 cycles of simultaneous push (incrementing from 0x0100) and pop -> count stays 3, output order matches input order across pointer wrap 7->0, no loss or duplication.
- Full boundary with pop: at count=8, drive in_valid=1 and out_ready=1 for one cycle -> only the pop occurs, count=7, the offered word is not stored; next cycle it is accepted, count=8.
- Reset mid-stream: with count=5 and push+pop active, assert rst for 1 cycle -> next cycle matches reset values; a subsequent push of 0xBEEF appears as out_data=0xBEEF one cycle later.
